pem_pc_rd_merge: RTL and testbench

Merges in-order read-response streams from PC_NB HBM pseudo-channels into one output stream. Words of a logical PEM read are interleaved round-robin across the pseudo-channels, one DATA_W word per PC per turn. This block consumes from each PC in that order and emits a single ordered stream. It sits between the per-PC AXI read-data paths and the PEM load datapath; PC_NB is sized by the top's PEM pseudo-channel maximum (2).

---
 rtl/pem_pc_rd_merge.sv | 132 +++++++++++++
 tb/tb_pem_pc_rd_merge.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pem_pc_rd_merge.sv
// Merges in-order read-response streams from PC_NB HBM pseudo-channels into a
// single ordered word stream, consuming from one pseudo-channel per turn in round-robin order.
module pem_pc_rd_merge #(
    parameter int PC_NB  = 2,
    parameter int DATA_W = 512,
    parameter int CNT_W  = 16,
    parameter int PC_W   = (PC_NB > 1) ? $clog2(PC_NB) : 1
) (
    input  logic                     clk,
    input  logic                     a_rst,
    input  logic                     cmd_vld,
    output logic                     cmd_rdy,
    input  logic [CNT_W-1:0]         cmd_word_nb,
    input  logic [PC_W-1:0]          cmd_pc_start,
    input  logic [PC_NB*DATA_W-1:0]  pc_data,
    input  logic [PC_NB-1:0]         pc_vld,
    output logic [PC_NB-1:0]         pc_rdy,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic                     out_last,
    output logic                     done,
    output logic                     busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t             state_r;
    logic [PC_W-1:0]    ptr_r;
    logic [CNT_W-1:0]   remaining_r;

    logic               load_en_s;
    logic               sel_vld_s;
    logic [DATA_W-1:0]  sel_data_s;
    logic               take_s;
    logic [PC_W-1:0]    ptr_nxt_s;

    // Output register can accept a new word when empty or being drained this cycle.
    assign load_en_s = !out_vld || out_rdy;
    assign take_s    = (state_r == ST_RUN) && load_en_s && sel_vld_s;
    assign ptr_nxt_s = (ptr_r == PC_W'(PC_NB - 1)) ? {PC_W{1'b0}} : ptr_r + PC_W'(1);
    assign cmd_rdy   = (state_r == ST_IDLE);

    // AND-OR select of the data/valid of the pseudo-channel currently owning the turn.
    always_comb begin
        sel_data_s = {DATA_W{1'b0}};
        sel_vld_s  = 1'b0;
        for (int i = 0; i < PC_NB; i++) begin
            sel_data_s = sel_data_s | (pc_data[i*DATA_W +: DATA_W] & {DATA_W{ptr_r == PC_W'(i)}});
            sel_vld_s  = sel_vld_s | (pc_vld[i] & (ptr_r == PC_W'(i)));
        end
    end

    // Only the selected pseudo-channel is offered ready; it never depends on pc_vld.
    always_comb begin
        pc_rdy = {PC_NB{1'b0}};
        for (int i = 0; i < PC_NB; i++) begin
            pc_rdy[i] = (state_r == ST_RUN) && load_en_s && (ptr_r == PC_W'(i));
        end
    end

    // Command FSM with the output register and all registered status outputs.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state_r     <= ST_IDLE;
            ptr_r       <= {PC_W{1'b0}};
            remaining_r <= {CNT_W{1'b0}};
            out_data    <= {DATA_W{1'b0}};
            out_vld     <= 1'b0;
            out_last    <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (cmd_vld) begin
                        remaining_r <= cmd_word_nb;
                        ptr_r       <= cmd_pc_start;
                        busy        <= 1'b1;
                        if (cmd_word_nb == CNT_W'(0)) begin
                            state_r <= ST_DONE;
                            done    <= 1'b1;
                        end else begin
                            state_r <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (take_s) begin
                        out_data    <= sel_data_s;
                        out_vld     <= 1'b1;
                        out_last    <= (remaining_r == CNT_W'(1));
                        remaining_r <= remaining_r - CNT_W'(1);
                        ptr_r       <= ptr_nxt_s;
                        if (remaining_r == CNT_W'(1)) begin
                            state_r <= ST_DRAIN;
                        end
                    end else if (out_vld && out_rdy) begin
                        out_vld  <= 1'b0;
                        out_last <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    // Only the final word can sit in the register here.
                    if (out_vld && out_rdy) begin
                        out_vld  <= 1'b0;
                        out_last <= 1'b0;
                        if (out_last) begin
                            state_r <= ST_DONE;
                            done    <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pem_pc_rd_merge.sv
// Self-checking bench for pem_pc_rd_merge: table-driven commands, random commands
// and an asynchronous mid-run reset, all checked against a round-robin order model.
module tb_pem_pc_rd_merge;

    localparam int PC_NB = 2;
    localparam int DW    = 32;
    localparam int CW    = 16;
    localparam int PW    = 1;

    logic                 clk = 1'b0;
    logic                 a_rst;
    logic                 cmd_vld;
    logic                 cmd_rdy;
    logic [CW-1:0]        cmd_word_nb;
    logic [PW-1:0]        cmd_pc_start;
    logic [PC_NB*DW-1:0]  pc_data;
    logic [PC_NB-1:0]     pc_vld;
    logic [PC_NB-1:0]     pc_rdy;
    logic [DW-1:0]        out_data;
    logic                 out_vld;
    logic                 out_rdy;
    logic                 out_last;
    logic                 done;
    logic                 busy;

    pem_pc_rd_merge #(.PC_NB(PC_NB), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .a_rst(a_rst), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .cmd_word_nb(cmd_word_nb), .cmd_pc_start(cmd_pc_start),
        .pc_data(pc_data), .pc_vld(pc_vld), .pc_rdy(pc_rdy),
        .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
        .out_last(out_last), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DW-1:0] d;
        logic          last;
    } ow_t;

    typedef struct {
        int n;
        int start;
        int vld_pct;
        int rdy_pct;
        int stall_at;
        int off_at;
        int exp_last_pc;
    } vec_t;

    int            checks = 0;
    int            errors = 0;
    int            src_idx [PC_NB];
    ow_t           got [$];
    logic          prev_vld, prev_rdy, prev_hs;
    logic [DW-1:0] prev_data, prev_hs_data;
    int            hs_pc;
    int            first_acc_cyc, last_acc_cyc, done_cyc, done_cnt, acc_cyc;

    function automatic logic [DW-1:0] word_of(input int pc, input int idx);
        logic [DW-1:0] w;
        w = (DW'(pc + 1) << 24) | DW'(idx & 32'h00FF_FFFF);
        return w;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive_pc();
        for (int i = 0; i < PC_NB; i++) pc_data[i*DW +: DW] = word_of(i, src_idx[i]);
    endtask

    task automatic clear_hist();
        prev_vld = 1'b0; prev_rdy = 1'b0; prev_hs = 1'b0;
        prev_data = '0; prev_hs_data = '0; hs_pc = 0;
    endtask

    // One clock cycle: apply inputs, sample mid-cycle, record handshakes, advance sources.
    task automatic tick(input logic [PC_NB-1:0] vld, input logic rdy);
        pc_vld  = vld;
        out_rdy = rdy;
        drive_pc();
        @(negedge clk);
        check("pc_rdy_onehot", DW'($countones(pc_rdy) <= 1), 32'd1);
        if (prev_vld && !prev_rdy) begin
            check("hold_vld", DW'(out_vld), 32'd1);
            check("hold_data", out_data, prev_data);
        end
        if (prev_hs) begin
            check("latency_vld", DW'(out_vld), 32'd1);
            check("latency_data", out_data, prev_hs_data);
        end
        if (out_vld && !out_rdy) check("stall_pc_rdy", DW'(pc_rdy), 32'd0);
        if (out_vld && out_rdy) begin
            got.push_back('{d: out_data, last: out_last});
            if (got.size() == 1) first_acc_cyc = cyc;
            if (out_last) last_acc_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("done_cmd_rdy", DW'(cmd_rdy), 32'd0);
        end
        prev_hs = 1'b0;
        for (int i = 0; i < PC_NB; i++) begin
            if (pc_vld[i] && pc_rdy[i]) begin
                prev_hs      = 1'b1;
                prev_hs_data = pc_data[i*DW +: DW];
                hs_pc        = i;
            end
        end
        prev_vld  = out_vld;
        prev_rdy  = out_rdy;
        prev_data = out_data;
        @(posedge clk);
        #1;
        if (prev_hs) src_idx[hs_pc]++;
    endtask

    task automatic issue(input int n, input int start);
        check("cmd_rdy_idle", DW'(cmd_rdy), 32'd1);
        got.delete();
        done_cnt = 0; done_cyc = -1; last_acc_cyc = -1; first_acc_cyc = -1;
        cmd_vld      = 1'b1;
        cmd_word_nb  = CW'(n);
        cmd_pc_start = PW'(start);
        acc_cyc      = cyc;
        tick('1, 1'b1);
        cmd_vld = 1'b0;
    endtask

    // Issue a command and check the merged stream against the round-robin model.
    task automatic run_cmd(input vec_t v);
        logic [DW-1:0] exp_q [$];
        int            tmp [PC_NB];
        logic [PC_NB-1:0] vld;
        logic          rdy;
        int            pc;
        for (int i = 0; i < PC_NB; i++) tmp[i] = src_idx[i];
        for (int k = 0; k < v.n; k++) begin
            pc = (v.start + k) % PC_NB;
            exp_q.push_back(word_of(pc, tmp[pc]));
            tmp[pc]++;
        end
        issue(v.n, v.start);
        for (int c = 0; c < 200 + 50 * v.n; c++) begin
            if (done_cnt != 0) break;
            for (int i = 0; i < PC_NB; i++) vld[i] = (int'($urandom_range(99)) < v.vld_pct);
            rdy = (int'($urandom_range(99)) < v.rdy_pct);
            if (v.off_at >= 0 && c >= v.off_at && c < v.off_at + 4) begin
                vld[0] = 1'b0;
                vld[1] = 1'b1;
            end
            if (v.stall_at >= 0 && c >= v.stall_at && c < v.stall_at + 5) rdy = 1'b0;
            tick(vld, rdy);
        end
        check("done_seen", DW'(done_cnt), 32'd1);
        @(negedge clk);
        check("done_pulse_width", DW'(done), 32'd0);
        check("cmd_rdy_back", DW'(cmd_rdy), 32'd1);
        check("busy_idle", DW'(busy), 32'd0);
        @(posedge clk);
        #1;
        clear_hist();
        check("word_count", DW'(got.size()), DW'(v.n));
        for (int k = 0; k < v.n && k < got.size(); k++) begin
            check("word_data", got[k].d, exp_q[k]);
            check("word_last", DW'(got[k].last), DW'(k == v.n - 1));
        end
        if (v.n == 0) begin
            check("zero_done_time", DW'(done_cyc), DW'(acc_cyc + 1));
        end else begin
            check("done_time", DW'(done_cyc), DW'(last_acc_cyc + 1));
            if (got.size() == v.n && v.exp_last_pc >= 0)
                check("last_pc", DW'(got[v.n-1].d[31:24] - 8'd1), DW'(v.exp_last_pc));
            if (v.vld_pct == 100 && v.rdy_pct == 100 && v.stall_at < 0 && v.off_at < 0)
                check("full_rate", DW'(last_acc_cyc - first_acc_cyc), DW'(v.n - 1));
        end
    endtask

    vec_t tbl [10];
    vec_t rv;

    initial begin
        tbl[0] = '{n: 6,  start: 0, vld_pct: 100, rdy_pct: 100, stall_at: -1, off_at: -1, exp_last_pc: 1};
        tbl[1] = '{n: 3,  start: 1, vld_pct: 100, rdy_pct: 100, stall_at: -1, off_at: -1, exp_last_pc: 1};
        tbl[2] = '{n: 10, start: 0, vld_pct: 100, rdy_pct: 100, stall_at: 3,  off_at: -1, exp_last_pc: 1};
        tbl[3] = '{n: 8,  start: 0, vld_pct: 100, rdy_pct: 100, stall_at: -1, off_at: 2,  exp_last_pc: 1};
        tbl[4] = '{n: 0,  start: 1, vld_pct: 100, rdy_pct: 100, stall_at: -1, off_at: -1, exp_last_pc: -1};
        tbl[5] = '{n: 1,  start: 1, vld_pct: 100, rdy_pct: 100, stall_at: -1, off_at: -1, exp_last_pc: 1};
        tbl[6] = '{n: 7,  start: 1, vld_pct: 60,  rdy_pct: 70,  stall_at: -1, off_at: -1, exp_last_pc: 1};
        tbl[7] = '{n: 9,  start: 0, vld_pct: 50,  rdy_pct: 50,  stall_at: -1, off_at: -1, exp_last_pc: 0};
        tbl[8] = '{n: 5,  start: 0, vld_pct: 80,  rdy_pct: 30,  stall_at: -1, off_at: -1, exp_last_pc: 0};
        tbl[9] = '{n: 12, start: 1, vld_pct: 70,  rdy_pct: 90,  stall_at: 4,  off_at: 1,  exp_last_pc: 0};

        for (int i = 0; i < PC_NB; i++) src_idx[i] = 0;
        clear_hist();
        a_rst = 1'b1; cmd_vld = 1'b0; cmd_word_nb = '0; cmd_pc_start = '0;
        pc_vld = '0; out_rdy = 1'b0;
        drive_pc();
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd_rdy", DW'(cmd_rdy), 32'd1);
        check("rst_pc_rdy", DW'(pc_rdy), 32'd0);
        check("rst_out_vld", DW'(out_vld), 32'd0);
        check("rst_out_last", DW'(out_last), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_done", DW'(done), 32'd0);
        check("rst_busy", DW'(busy), 32'd0);
        a_rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[t]) run_cmd(tbl[t]);

        for (int r = 0; r < 20; r++) begin
            rv.n        = int'($urandom_range(20));
            rv.start    = int'($urandom_range(1));
            rv.vld_pct  = 30 + int'($urandom_range(70));
            rv.rdy_pct  = 30 + int'($urandom_range(70));
            rv.stall_at = -1;
            rv.off_at   = -1;
            rv.exp_last_pc = (rv.start + rv.n - 1) % PC_NB;
            run_cmd(rv);
        end

        // Asynchronous reset in the middle of a running command.
        issue(8, 0);
        repeat (3) tick('1, 1'b1);
        #3 a_rst = 1'b1;
        #1;
        check("arst_cmd_rdy", DW'(cmd_rdy), 32'd1);
        check("arst_pc_rdy", DW'(pc_rdy), 32'd0);
        check("arst_out_vld", DW'(out_vld), 32'd0);
        check("arst_out_last", DW'(out_last), 32'd0);
        check("arst_out_data", out_data, 32'd0);
        check("arst_done", DW'(done), 32'd0);
        check("arst_busy", DW'(busy), 32'd0);
        @(posedge clk);
        #1;
        a_rst = 1'b0;
        clear_hist();
        rv = '{n: 4, start: 1, vld_pct: 100, rdy_pct: 100, stall_at: -1, off_at: -1, exp_last_pc: 0};
        run_cmd(rv);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
